tile_mem_arbiter: RTL and testbench
===================================

TILE_MEM_ARBITER -- requirements
Module: tile_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 13: per-bank word address width.
REQ-003 SHALL have parameter DATA_W, default 64: per-bank data width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept; transfer when valid and ready are both 1.
REQ-008 SHALL have port req_we  input  NUM_REQ  1 = write, 0 = read.
REQ-009 SHALL have port req_bank  input  2*NUM_REQ  target bank 0..3; requester i in bits [2i+1:2i].
REQ-010 SHALL have port req_addr  input  ADDR_W*NUM_REQ  word address, packed like req_bank.
REQ-011 SHALL have port req_wdata  input  DATA_W*NUM_REQ  write data, packed like req_bank.
REQ-012 SHALL have port rsp_valid  output  NUM_REQ  read data valid, one pulse per accepted read.
REQ-013 SHALL have port rsp_rdata  output  DATA_W*NUM_REQ  read data, packed like req_bank.
REQ-014 SHALL have ports mem_bank_enable/mem_bank_write_en  output  4 each  bank strobes, registered.
REQ-015 SHALL have ports mem_bank_addr  output  4*ADDR_W and mem_bank_wdata  output  4*DATA_W; bank b in slice b.
REQ-016 SHALL have ports mem_bank_rdata  input  4*DATA_W and mem_bank_ready  input  4  bank can accept access.
REQ-017 SHALL have port conflict_count  output  16  perf counter (see Configuration).

Function
REQ-018 SHALL arbitrate each bank independently; up to 4 requests accepted per cycle, at most one per bank.
REQ-019 SHALL consider bank b for grant only when mem_bank_ready[b]=1; otherwise no requester targeting b gets req_ready.
REQ-020 SHALL grant per bank by round-robin: search starts at rr_ptr[b]; on a grant to i, rr_ptr[b] <= (i+1) mod NUM_REQ.
REQ-021 SHALL drive req_ready combinationally in the same cycle; req_ready[i]=1 only if req_valid[i]=1 and i won its bank.
REQ-022 SHALL hold rr_ptr[b] when bank b issues no grant.
REQ-023 SHALL register the accepted request into bank b: enable, write_en=req_we, addr, wdata driven in cycle T+1 for acceptance at T.
REQ-024 SHALL force mem_bank_enable[b] and mem_bank_write_en[b] to 0 in any cycle following no grant on b; addr/wdata hold last value.
REQ-025 SHALL sample mem_bank_rdata[b] in cycle T+2 for a read accepted at T, pulsing rsp_valid[i] for one cycle with that data.
REQ-026 SHALL keep rsp_rdata[i] at its last value when rsp_valid[i]=0.
REQ-027 SHALL track read owner per bank in a 2-stage pipeline so back-to-back reads to one bank from different requesters return in order, one per cycle.
REQ-028 SHALL return reads from different banks to different requesters in the same cycle.
REQ-029 SHALL not produce rsp_valid for writes.
REQ-030 SHALL tolerate requester i changing req_bank while not accepted; arbitration uses the current cycle's values only.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear rr_ptr to 0, all mem_bank_* outputs to 0, rsp_valid to 0, rsp_rdata to 0, read-owner pipeline to empty, and conflict_count to 0.
REQ-032 SHALL discard reads in flight at reset; no rsp_valid after deassertion for requests accepted before reset.
REQ-033 SHALL hold req_ready at 0 while rst_n is low.

Configuration
REQ-034 SHALL, with macro TILE_MEM_ARB_PERF_EN defined, increment conflict_count once per cycle per bank having at least 2 valid requests or a valid request while not ready, saturating at 16'hFFFF.
REQ-035 SHALL, with TILE_MEM_ARB_PERF_EN undefined, tie conflict_count to 0 and synthesize no counter logic.

Verification
REQ-036 SHALL cover: reqs 0,1,2 all read bank 2 continuously, ready=1 -> grants 0,1,2,0,... one per cycle; rsp_valid to each 2 cycles after its grant.
REQ-037 SHALL cover: req0 write bank0 addr 0x010 data 0xA5A5 at T -> mem_bank_enable=0001, write_en=0001, addr slice0=0x010 at T+1; no rsp_valid.
REQ-038 SHALL cover: req0 bank1 and req1 bank3 reads same cycle -> both req_ready=1, both rsp_valid at T+2 with matching bank data.
REQ-039 SHALL cover: mem_bank_ready[2]=0 for 3 cycles with req1 valid to bank 2 -> req_ready[1]=0 for 3 cycles, grant in cycle 4; with TILE_MEM_ARB_PERF_EN, conflict_count=3.
REQ-040 SHALL cover: rst_n asserted 1 cycle after a read accepted -> all outputs 0, rr_ptr 0, no rsp_valid after release.

Source files
------------

// File: rtl/tile_mem_arbiter.sv
// Four-bank memory arbiter: per-bank round-robin grant, registered bank strobes, in-order read return.
// Define TILE_MEM_ARB_PERF_EN to build the saturating conflict_count perf counter.
module tile_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [2*NUM_REQ-1:0]      req_bank,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W*NUM_REQ-1:0] rsp_rdata,
    output logic [3:0]                mem_bank_enable,
    output logic [3:0]                mem_bank_write_en,
    output logic [4*ADDR_W-1:0]       mem_bank_addr,
    output logic [4*DATA_W-1:0]       mem_bank_wdata,
    input  logic [4*DATA_W-1:0]       mem_bank_rdata,
    input  logic [3:0]                mem_bank_ready,
    output logic [15:0]               conflict_count
);

    localparam int PW = 3;

    logic [PW-1:0]             r_rr_ptr [4];
    logic [3:0]                r_bank_en;
    logic [3:0]                r_bank_we;
    logic [4*ADDR_W-1:0]       r_bank_addr;
    logic [4*DATA_W-1:0]       r_bank_wdata;
    logic [3:0]                r_s1_v;
    logic [3:0]                r_s2_v;
    logic [PW-1:0]             r_s1_own [4];
    logic [PW-1:0]             r_s2_own [4];
    logic [DATA_W*NUM_REQ-1:0] r_rsp_hold;

    logic [3:0]        w_gnt;
    logic [PW-1:0]     w_gnt_idx [4];
    logic [3:0]        w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr [4];
    logic [DATA_W-1:0] w_sel_wdata [4];

    // Search each bank starting at its pointer; first matching requester wins.
    always_comb begin
        int j;
        j = 0;
        w_gnt    = '0;
        w_sel_we = '0;
        for (int b = 0; b < 4; b++) begin
            w_gnt_idx[b]   = '0;
            w_sel_addr[b]  = '0;
            w_sel_wdata[b] = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (int'(r_rr_ptr[b]) + k) % NUM_REQ;
                if (!w_gnt[b] && rst_n && mem_bank_ready[b] && req_valid[j]
                    && (req_bank[2*j +: 2] == 2'(b))) begin
                    w_gnt[b]       = 1'b1;
                    w_gnt_idx[b]   = PW'(j);
                    w_sel_we[b]    = req_we[j];
                    w_sel_addr[b]  = req_addr[ADDR_W*j +: ADDR_W];
                    w_sel_wdata[b] = req_wdata[DATA_W*j +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (w_gnt[b] && (w_gnt_idx[b] == PW'(i))) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_en    <= '0;
            r_bank_we    <= '0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_s1_v       <= '0;
            r_s2_v       <= '0;
            r_rsp_hold   <= '0;
            for (int b = 0; b < 4; b++) begin
                r_rr_ptr[b] <= '0;
                r_s1_own[b] <= '0;
                r_s2_own[b] <= '0;
            end
        end else begin
            r_bank_en  <= w_gnt;
            r_bank_we  <= w_gnt & w_sel_we;
            r_s1_v     <= w_gnt & ~w_sel_we;
            r_s2_v     <= r_s1_v;
            r_rsp_hold <= rsp_rdata;
            for (int b = 0; b < 4; b++) begin
                r_s1_own[b] <= w_gnt_idx[b];
                r_s2_own[b] <= r_s1_own[b];
                if (w_gnt[b]) begin
                    r_rr_ptr[b] <= (w_gnt_idx[b] == PW'(NUM_REQ - 1)) ? '0
                                 : w_gnt_idx[b] + PW'(1);
                    r_bank_addr[ADDR_W*b +: ADDR_W]  <= w_sel_addr[b];
                    r_bank_wdata[DATA_W*b +: DATA_W] <= w_sel_wdata[b];
                end
            end
        end
    end

    // Stage-2 owner picks which requester sees this bank's read data.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = r_rsp_hold;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (r_s2_v[b] && (r_s2_own[b] == PW'(i))) begin
                    rsp_valid[i] = 1'b1;
                    rsp_rdata[DATA_W*i +: DATA_W] = mem_bank_rdata[DATA_W*b +: DATA_W];
                end
            end
        end
    end

    assign mem_bank_enable   = r_bank_en;
    assign mem_bank_write_en = r_bank_we;
    assign mem_bank_addr     = r_bank_addr;
    assign mem_bank_wdata    = r_bank_wdata;

`ifdef TILE_MEM_ARB_PERF_EN
    logic [15:0] r_conf;
    logic [2:0]  w_conf_n;
    logic [16:0] w_conf_sum;

    always_comb begin
        int n;
        n = 0;
        w_conf_n = '0;
        for (int b = 0; b < 4; b++) begin
            n = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (req_bank[2*i +: 2] == 2'(b))) begin
                    n = n + 1;
                end
            end
            if ((n >= 2) || ((n == 1) && !mem_bank_ready[b])) begin
                w_conf_n = w_conf_n + 3'd1;
            end
        end
    end

    assign w_conf_sum = {1'b0, r_conf} + {14'b0, w_conf_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conf <= '0;
        end else begin
            r_conf <= w_conf_sum[16] ? 16'hFFFF : w_conf_sum[15:0];
        end
    end

    assign conflict_count = r_conf;
`else
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Directed self-checking bench for tile_mem_arbiter (NUM_REQ=3, ADDR_W=13, DATA_W=64).
module tb_tile_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [2:0]   req_we;
    logic [5:0]   req_bank;
    logic [38:0]  req_addr;
    logic [191:0] req_wdata;
    logic [2:0]   rsp_valid;
    logic [191:0] rsp_rdata;
    logic [3:0]   mem_bank_enable;
    logic [3:0]   mem_bank_write_en;
    logic [51:0]  mem_bank_addr;
    logic [255:0] mem_bank_wdata;
    logic [255:0] mem_bank_rdata;
    logic [3:0]   mem_bank_ready;
    logic [15:0]  conflict_count;

    int checks;
    int fails;

    localparam logic [63:0] BD0 = 64'h0B0B_0000_1111_0000;
    localparam logic [63:0] BD1 = 64'h1B1B_0000_2222_0001;
    localparam logic [63:0] BD2 = 64'h2B2B_0000_3333_0002;
    localparam logic [63:0] BD3 = 64'h3B3B_0000_4444_0003;

`ifdef TILE_MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    tile_mem_arbiter #(.NUM_REQ(3), .ADDR_W(13), .DATA_W(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_bank          (req_bank),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .mem_bank_enable   (mem_bank_enable),
        .mem_bank_write_en (mem_bank_write_en),
        .mem_bank_addr     (mem_bank_addr),
        .mem_bank_wdata    (mem_bank_wdata),
        .mem_bank_rdata    (mem_bank_rdata),
        .mem_bank_ready    (mem_bank_ready),
        .conflict_count    (conflict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
        req_bank  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [1:0] bk, input logic [12:0] a,
                           input logic [63:0] d);
        req_valid[i]         = v;
        req_we[i]            = w;
        req_bank[2*i +: 2]   = bk;
        req_addr[13*i +: 13] = a;
        req_wdata[64*i +: 64] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        mem_bank_ready = 4'hF;
        set_req(0, 1'b1, 1'b0, 2'd0, 13'h1, 64'h0);
        set_req(1, 1'b1, 1'b0, 2'd0, 13'h2, 64'h0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 3'b000) begin fails++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
        checks++; if (mem_bank_enable !== 4'b0000) begin fails++; $display("FAIL rst_en got=%b exp=0000", mem_bank_enable); end
        checks++; if (mem_bank_write_en !== 4'b0000) begin fails++; $display("FAIL rst_we got=%b exp=0000", mem_bank_write_en); end
        checks++; if (mem_bank_addr !== 52'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", mem_bank_addr); end
        checks++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL rst_rspv got=%b exp=000", rsp_valid); end
        checks++; if (rsp_rdata !== 192'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (conflict_count !== 16'h0) begin fails++; $display("FAIL rst_conf got=%0d exp=0", conflict_count); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [2:0]  e_rdy;
        logic [2:0]  e_rsp;
        logic [3:0]  e_en;
        logic [15:0] e_conf;
        int          r;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            idle();
            if (t < 6) begin
                for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 2'd2, 13'h100 + 13'(i), 64'h0);
            end
            #1;
            e_rdy = (t < 6) ? 3'(1 << (t % 3)) : 3'b000;
            e_rsp = (t >= 2) ? 3'(1 << ((t - 2) % 3)) : 3'b000;
            e_en  = (t >= 1 && t <= 6) ? 4'b0100 : 4'b0000;
            checks++; if (req_ready !== e_rdy) begin fails++; $display("FAIL rr_ready t=%0d got=%b exp=%b", t, req_ready, e_rdy); end
            checks++; if (rsp_valid !== e_rsp) begin fails++; $display("FAIL rr_rspv t=%0d got=%b exp=%b", t, rsp_valid, e_rsp); end
            checks++; if (mem_bank_enable !== e_en) begin fails++; $display("FAIL rr_en t=%0d got=%b exp=%b", t, mem_bank_enable, e_en); end
            if (t >= 1 && t <= 6) begin
                checks++; if (mem_bank_addr[26 +: 13] !== 13'h100 + 13'((t - 1) % 3)) begin fails++; $display("FAIL rr_addr t=%0d got=%h exp=%h", t, mem_bank_addr[26 +: 13], 13'h100 + 13'((t - 1) % 3)); end
            end
            if (t >= 2) begin
                r = (t - 2) % 3;
                checks++; if (rsp_rdata[64*r +: 64] !== BD2) begin fails++; $display("FAIL rr_rdata t=%0d got=%h exp=%h", t, rsp_rdata[64*r +: 64], BD2); end
            end
        end
        e_conf = PERF ? 16'd6 : 16'd0;
        checks++; if (conflict_count !== e_conf) begin fails++; $display("FAIL rr_conf got=%0d exp=%0d", conflict_count, e_conf); end
    endtask

    task automatic test_not_ready();
        logic [2:0]  e_rdy;
        logic [15:0] e_conf;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            idle();
            set_req(1, 1'b1, 1'b0, 2'd2, 13'h022, 64'h0);
            mem_bank_ready = (t < 3) ? 4'b1011 : 4'b1111;
            #1;
            e_rdy = (t < 3) ? 3'b000 : 3'b010;
            checks++; if (req_ready !== e_rdy) begin fails++; $display("FAIL nr_ready t=%0d got=%b exp=%b", t, req_ready, e_rdy); end
        end
        @(negedge clk);
        idle();
        #1;
        e_conf = PERF ? 16'd9 : 16'd0;
        checks++; if (mem_bank_enable !== 4'b0100) begin fails++; $display("FAIL nr_en got=%b exp=0100", mem_bank_enable); end
        checks++; if (mem_bank_addr[26 +: 13] !== 13'h022) begin fails++; $display("FAIL nr_addr got=%h exp=022", mem_bank_addr[26 +: 13]); end
        checks++; if (conflict_count !== e_conf) begin fails++; $display("FAIL nr_conf got=%0d exp=%0d", conflict_count, e_conf); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 3'b010) begin fails++; $display("FAIL nr_rspv got=%b exp=010", rsp_valid); end
        checks++; if (rsp_rdata[64 +: 64] !== BD2) begin fails++; $display("FAIL nr_rdata got=%h exp=%h", rsp_rdata[64 +: 64], BD2); end
    endtask

    task automatic test_write();
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 1'b1, 2'd0, 13'h010, 64'hA5A5);
        #1;
        checks++; if (req_ready !== 3'b001) begin fails++; $display("FAIL wr_ready got=%b exp=001", req_ready); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (mem_bank_enable !== 4'b0001) begin fails++; $display("FAIL wr_en got=%b exp=0001", mem_bank_enable); end
        checks++; if (mem_bank_write_en !== 4'b0001) begin fails++; $display("FAIL wr_we got=%b exp=0001", mem_bank_write_en); end
        checks++; if (mem_bank_addr[0 +: 13] !== 13'h010) begin fails++; $display("FAIL wr_addr got=%h exp=010", mem_bank_addr[0 +: 13]); end
        checks++; if (mem_bank_wdata[0 +: 64] !== 64'hA5A5) begin fails++; $display("FAIL wr_wdata got=%h exp=a5a5", mem_bank_wdata[0 +: 64]); end
        checks++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL wr_rspv1 got=%b exp=000", rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (mem_bank_enable !== 4'b0000) begin fails++; $display("FAIL wr_en2 got=%b exp=0000", mem_bank_enable); end
        checks++; if (mem_bank_write_en !== 4'b0000) begin fails++; $display("FAIL wr_we2 got=%b exp=0000", mem_bank_write_en); end
        checks++; if (mem_bank_addr[0 +: 13] !== 13'h010) begin fails++; $display("FAIL wr_addr_hold got=%h exp=010", mem_bank_addr[0 +: 13]); end
        checks++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL wr_rspv2 got=%b exp=000", rsp_valid); end
    endtask

    task automatic test_two_banks();
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 1'b0, 2'd1, 13'h005, 64'h0);
        set_req(1, 1'b1, 1'b0, 2'd3, 13'h007, 64'h0);
        #1;
        checks++; if (req_ready !== 3'b011) begin fails++; $display("FAIL tb_ready got=%b exp=011", req_ready); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (mem_bank_enable !== 4'b1010) begin fails++; $display("FAIL tb_en got=%b exp=1010", mem_bank_enable); end
        checks++; if (mem_bank_write_en !== 4'b0000) begin fails++; $display("FAIL tb_we got=%b exp=0000", mem_bank_write_en); end
        checks++; if (mem_bank_addr[39 +: 13] !== 13'h007) begin fails++; $display("FAIL tb_addr3 got=%h exp=007", mem_bank_addr[39 +: 13]); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 3'b011) begin fails++; $display("FAIL tb_rspv got=%b exp=011", rsp_valid); end
        checks++; if (rsp_rdata[0 +: 64] !== BD1) begin fails++; $display("FAIL tb_rdata0 got=%h exp=%h", rsp_rdata[0 +: 64], BD1); end
        checks++; if (rsp_rdata[64 +: 64] !== BD3) begin fails++; $display("FAIL tb_rdata1 got=%h exp=%h", rsp_rdata[64 +: 64], BD3); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL tb_rspv_end got=%b exp=000", rsp_valid); end
        checks++; if (rsp_rdata[0 +: 64] !== BD1) begin fails++; $display("FAIL tb_rdata_hold got=%h exp=%h", rsp_rdata[0 +: 64], BD1); end
    endtask

    task automatic test_reset_flight();
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 1'b0, 2'd0, 13'h030, 64'h0);
        set_req(1, 1'b1, 1'b0, 2'd0, 13'h031, 64'h0);
        #1;
        checks++; if (req_ready !== 3'b010) begin fails++; $display("FAIL rf_ready got=%b exp=010", req_ready); end
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (mem_bank_enable !== 4'b0000) begin fails++; $display("FAIL rf_en got=%b exp=0000", mem_bank_enable); end
        checks++; if (mem_bank_addr !== 52'h0) begin fails++; $display("FAIL rf_addr got=%h exp=0", mem_bank_addr); end
        checks++; if (mem_bank_wdata !== 256'h0) begin fails++; $display("FAIL rf_wdata got=%h exp=0", mem_bank_wdata); end
        checks++; if (rsp_rdata !== 192'h0) begin fails++; $display("FAIL rf_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (conflict_count !== 16'h0) begin fails++; $display("FAIL rf_conf got=%0d exp=0", conflict_count); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 3'b000) begin fails++; $display("FAIL rf_rspv t=%0d got=%b exp=000", t, rsp_valid); end
        end
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 2'd0, 13'h030, 64'h0);
        set_req(1, 1'b1, 1'b0, 2'd0, 13'h031, 64'h0);
        #1;
        checks++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rf_ptr got=%b exp=001", req_ready); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        mem_bank_rdata = {BD3, BD2, BD1, BD0};
        mem_bank_ready = 4'hF;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_round_robin();
        test_not_ready();
        test_write();
        test_two_banks();
        test_reset_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
